vga_scene_renderer: RTL



---
 rtl/vga_scene_renderer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_scene_renderer.sv
// vga_scene_renderer
//
// VGA scan generator and sprite compositor for the frog game. It draws one
// frog and NUM_CARS car squares over an optional grid background. Sprite
// positions and colours are copied into shadow registers once per frame, so
// a sprite never tears mid-frame. A pixel-level frog/car overlap flag is
// gathered over each frame and reported when the frame wraps.
//
// Ports
//   clk, reset            pixel clock, synchronous active-high reset
//   grid_en               1 = draw grid lines every GRID_SIZE pixels
//   frog_x, frog_y        frog top-left corner
//   car_x_bus, car_y_bus  car i top-left at bits [10i+9:10i]
//   car_color_bus         car i {r,g,b} at bits [9i+8:9i]
//   red, green, blue      registered 3-3-3 pixel colour
//   hsync, vsync          registered sync, polarity set by SYNC_ACTIVE_HIGH
//   pixel_x, pixel_y      coordinates of the pixel currently on red/green/blue
//   frame_start           one-cycle pulse while pixel (0,0) is presented
//   collision             frog/car overlap seen in the last completed frame
//   collision_valid       one-cycle pulse when collision is updated
//
// Handshake: there is none. Every output is a free-running registered stream
// that changes once per pixel clock; consumers sample it each cycle.
//
// Pipeline: counters -> combinational compose -> output registers. All
// outputs are mutually aligned and lag the counters by one cycle.

module vga_scene_renderer #(
    parameter int         H_DISPLAY        = 640,
    parameter int         H_FRONT          = 16,
    parameter int         H_SYNC           = 96,
    parameter int         H_BACK           = 48,
    parameter int         V_DISPLAY        = 480,
    parameter int         V_FRONT          = 10,
    parameter int         V_SYNC           = 2,
    parameter int         V_BACK           = 33,
    parameter int         NUM_CARS         = 10,
    parameter int         CAR_SIZE         = 32,
    parameter int         FROG_SIZE        = 32,
    parameter int         GRID_SIZE        = 32,
    parameter int         SYNC_ACTIVE_HIGH = 1,
    parameter logic [8:0] FROG_COLOR       = 9'b000_111_000,
    parameter logic [8:0] GRID_COLOR       = 9'b100_100_100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     grid_en,
    input  logic [9:0]               frog_x,
    input  logic [9:0]               frog_y,
    input  logic [10*NUM_CARS-1:0]   car_x_bus,
    input  logic [10*NUM_CARS-1:0]   car_y_bus,
    input  logic [9*NUM_CARS-1:0]    car_color_bus,
    output logic [2:0]               red,
    output logic [2:0]               green,
    output logic [2:0]               blue,
    output logic                     hsync,
    output logic                     vsync,
    output logic [9:0]               pixel_x,
    output logic [9:0]               pixel_y,
    output logic                     frame_start,
    output logic                     collision,
    output logic                     collision_valid
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT     = 10'(H_DISPLAY);
    localparam logic [9:0]  V_ACT     = 10'(V_DISPLAY);
    localparam logic [9:0]  HS_START  = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]  HS_END    = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0]  VS_START  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]  VS_END    = 10'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [9:0]  GRID_MASK = 10'(GRID_SIZE - 1);
    localparam logic [10:0] CAR_SZ    = 11'(CAR_SIZE);
    localparam logic [10:0] FROG_SZ   = 11'(FROG_SIZE);
    localparam logic        SYNC_ON   = (SYNC_ACTIVE_HIGH != 0);

    // Scan counters
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       line_wrap;
    logic       frame_wrap;

    // Shadowed sprite state, reloaded only at the frame wrap
    logic [9:0]             frog_x_q;
    logic [9:0]             frog_y_q;
    logic [10*NUM_CARS-1:0] car_x_q;
    logic [10*NUM_CARS-1:0] car_y_q;
    logic [9*NUM_CARS-1:0]  car_color_q;

    logic collision_acc;

    // Compose results
    logic       active;
    logic       frog_hit;
    logic       car_hit;
    logic [8:0] car_color;
    logic       grid_hit;
    logic [8:0] pixel_color;
    logic       hs_on;
    logic       vs_on;
    logic       collision_now;

    // Span test done in 11 bits so a sprite near column/row 1023 is clipped
    // at the edge instead of wrapping around to 0.
    function automatic logic in_span(input logic [9:0]  pos,
                                     input logic [9:0]  start,
                                     input logic [10:0] size);
        logic [10:0] pos_w;
        logic [10:0] start_w;
        pos_w   = {1'b0, pos};
        start_w = {1'b0, start};
        return (pos_w >= start_w) && (pos_w < (start_w + size));
    endfunction

    assign line_wrap  = (h_cnt == H_LAST);
    assign frame_wrap = line_wrap && (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frog_x_q    <= '0;
            frog_y_q    <= '0;
            car_x_q     <= '0;
            car_y_q     <= '0;
            car_color_q <= '0;
        end else if (frame_wrap) begin
            frog_x_q    <= frog_x;
            frog_y_q    <= frog_y;
            car_x_q     <= car_x_bus;
            car_y_q     <= car_y_bus;
            car_color_q <= car_color_bus;
        end
    end

    always_comb begin
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        frog_hit  = in_span(h_cnt, frog_x_q, FROG_SZ) && in_span(v_cnt, frog_y_q, FROG_SZ);
        car_hit   = 1'b0;
        car_color = 9'd0;
        // Walk from the highest index down so the lowest-index hit car is
        // the last writer and therefore supplies the colour.
        for (int i = NUM_CARS - 1; i >= 0; i--) begin
            if (in_span(h_cnt, car_x_q[10*i +: 10], CAR_SZ) &&
                in_span(v_cnt, car_y_q[10*i +: 10], CAR_SZ)) begin
                car_hit   = 1'b1;
                car_color = car_color_q[9*i +: 9];
            end
        end
        grid_hit = grid_en && (((h_cnt & GRID_MASK) == 10'd0) ||
                               ((v_cnt & GRID_MASK) == 10'd0));

        pixel_color = 9'd0;
        if (active) begin
            if (car_hit) begin
                pixel_color = car_color;
            end else if (frog_hit) begin
                pixel_color = FROG_COLOR;
            end else if (grid_hit) begin
                pixel_color = GRID_COLOR;
            end
        end

        hs_on         = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_on         = (v_cnt >= VS_START) && (v_cnt < VS_END);
        collision_now = active && frog_hit && car_hit;
    end

    // A hit in the wrap cycle itself is folded in before the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            collision_acc   <= 1'b0;
            collision       <= 1'b0;
            collision_valid <= 1'b0;
        end else if (frame_wrap) begin
            collision_acc   <= 1'b0;
            collision       <= collision_acc | collision_now;
            collision_valid <= 1'b1;
        end else begin
            collision_acc   <= collision_acc | collision_now;
            collision_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_start <= 1'b0;
        end else begin
            red         <= pixel_color[8:6];
            green       <= pixel_color[5:3];
            blue        <= pixel_color[2:0];
            hsync       <= hs_on ? SYNC_ON : ~SYNC_ON;
            vsync       <= vs_on ? SYNC_ON : ~SYNC_ON;
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
        end
    end

endmodule
